apb_master: RTL and testbench
=============================

Name: apb_master

Overview:
- APB requester (initiator) that drives the same pclk/prstn APB bus our UART-bridge slaves respond on.
- Accepts single-beat read/write commands on a valid/ready command port.
- Runs the APB SETUP and ACCESS phases, waits for pready and returns rdata/error on a valid/ready response port.
- Includes a wait-state timeout so a hung slave cannot lock the bus.

Parameters:
- ADDR_WIDTH, 8, width of paddr and cmd_addr.
- DATA_WIDTH, 8, width of pwdata, prdata, cmd_wdata and rsp_rdata.
- TIMEOUT, 16, maximum ACCESS cycles with pready=0 before abort; 0 disables the timeout.

Ports:
- pclk  in  1  clock.
- prstn  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_err  out  1  slave pslverr or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- paddr  out  ADDR_WIDTH  APB address.
- pselx  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  DATA_WIDTH  APB write data.
- pready  in  1  slave ready.
- prdata  in  DATA_WIDTH  slave read data.
- pslverr  in  1  slave error.

Behaviour:
- Clocking and reset:
  - Single clock pclk; reset prstn is asynchronous and active-low.
  - Reset is immediate and async. State=IDLE; pselx, penable, pwrite, rsp_valid, rsp_err and rsp_timeout=0; paddr, pwdata and rsp_rdata=0; wait counter=0.
- FSM states: IDLE, SETUP, ACCESS, RESP. All APB outputs are registered.
- cmd_ready = (state==IDLE), combinational. It reads 1 out of reset.
- IDLE:
  - On cmd_valid && cmd_ready, register cmd_addr to paddr, cmd_write to pwrite and cmd_wdata to pwdata.
  - Next cycle: pselx=1, penable=0, state=SETUP.
  - Without cmd_valid, remain in IDLE with pselx=0.
- SETUP: lasts exactly one cycle. Next cycle penable=1, state=ACCESS; paddr, pwrite and pwdata unchanged.
- ACCESS: pready is sampled on every rising edge.
  - pready=1:
    - rsp_rdata=prdata for reads and 0 for writes.
    - rsp_err=pslverr, rsp_timeout=0.
    - Next cycle: pselx=0, penable=0, rsp_valid=1, state=RESP.
  - pready=0: wait counter increments. pslverr and prdata are ignored.
  - Timeout (TIMEOUT!=0 and the counter reaches TIMEOUT, i.e. TIMEOUT consecutive wait cycles):
    - Abort with pselx=0, penable=0, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0, state=RESP.
  - The counter clears on leaving ACCESS. Counter width is clog2(TIMEOUT+1), minimum 1.
- RESP:
  - rsp_valid, rsp_rdata, rsp_err and rsp_timeout are held stable until rsp_ready=1.
  - That same edge: rsp_valid=0, state=IDLE.
- Latency:
  - Zero-wait transfer: accept edge T0, SETUP T1, ACCESS T2, rsp_valid visible after T2.
  - Best-case command-to-command spacing is 4 cycles. No pipelining; one outstanding transfer.
- paddr, pwrite and pwdata hold their last values while idle and change only on command accept.
- pselx is never high in IDLE or RESP. penable is high only in ACCESS and never without pselx.
- Reset mid-transfer drops pselx/penable asynchronously and discards the pending response. No response is issued.

Test Plan:
- Write, zero-wait: cmd write addr=0x04 wdata=0xA5, pready tied 1.
  - Required: pselx=1/penable=0 one cycle, then penable=1 one cycle, paddr=0x04, pwdata=0xA5, pwrite=1.
  - Required: rsp_valid with rsp_err=0, rsp_rdata=0x00.
- Read, 2 wait states: cmd read addr=0x00, pready=0 for 2 ACCESS cycles, then 1 with prdata=0x3C.
  - Required: penable high 3 cycles, rsp_rdata=0x3C, rsp_err=0.
- Slave error: read with pready=1, pslverr=1, prdata=0xFF.
  - Required: rsp_err=1, rsp_timeout=0, rsp_rdata=0xFF.
  - Also: pslverr=1 while pready=0 is ignored.
- Timeout: TIMEOUT=16, pready held 0.
  - Required: after 16 ACCESS wait cycles pselx and penable drop, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - Required: cmd_ready returns after rsp_ready.
- Backpressure and back-to-back: rsp_ready=0 for 5 cycles, second cmd_valid held.
  - Required: response stable, cmd_ready=0 throughout.
  - Required: second command accepted the cycle after rsp_ready, 4-cycle spacing when zero-wait.
- Reset mid-ACCESS: assert prstn=0 while penable=1.
  - Required: pselx, penable and rsp_valid go 0 immediately.
  - Required: after release, cmd_ready=1 and no stale response.

Source files
------------

// File: rtl/apb_master.sv
// APB requester: takes one read/write command at a time on a valid/ready
// command port and runs the APB SETUP and ACCESS phases. It returns read
// data and error status on a valid/ready response port. A wait-state
// timeout aborts the transfer when a slave never asserts pready.
//
// Handshake rule for both ports: a transfer happens on a rising pclk edge
// where valid and ready are both high. Once the producer raises valid, it
// holds valid and the payload stable until that edge. The response port
// also holds rsp_rdata, rsp_err and rsp_timeout stable while rsp_valid is
// high and rsp_ready is low.
module apb_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  pclk,
  input  logic                  prstn,
  // command port
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  // response port
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  // APB bus
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  pselx,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pslverr
);

  // The wait counter must hold values up to TIMEOUT-1. It keeps at least
  // one bit so that it stays legal when the timeout is disabled.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int LAST_WAIT_INT = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
  localparam logic [CW-1:0] LAST_WAIT = CW'(LAST_WAIT_INT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // The state is kept as a named variable so that checkers can bind to it
  // hierarchically.
  state_t        state;
  logic [CW-1:0] wait_cnt;

  // Only one transfer can be in flight, so a command is taken only in IDLE.
  assign cmd_ready = (state == IDLE);

  // Transfer sequencer. All bus and response outputs are registered here.
  // The wait counter counts the ACCESS cycles already spent with pready low.
  // The abort therefore fires on the edge that sees the TIMEOUT-th
  // consecutive wait cycle. A ready slave on that same edge still wins.
  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      state       <= IDLE;
      pselx       <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            paddr  <= cmd_addr;
            pwrite <= cmd_write;
            pwdata <= cmd_wdata;
            pselx  <= 1'b1;
            state  <= SETUP;
          end
        end

        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end

        ACCESS: begin
          if (pready) begin
            pselx       <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= pwrite ? '0 : prdata;
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
            wait_cnt    <= '0;
            state       <= RESP;
          end else if ((TIMEOUT != 0) && (wait_cnt == LAST_WAIT)) begin
            pselx       <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            wait_cnt    <= '0;
            state       <= RESP;
          end else if (TIMEOUT != 0) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Testbench for apb_master. The driver walks each transaction cycle by cycle
// and plays the APB slave. For every cycle it pushes the outputs the
// protocol requires, built from a transaction-level description:
//   - idle cycles
//   - one SETUP cycle
//   - waits+1 ACCESS cycles, or TIMEOUT cycles on a timeout
//   - rdelay+1 response cycles
// One compare process checks the DUT against that queue on every falling
// edge. Directed transactions add literal expectations on top of the model.
`timescale 1ns/1ps
module tb_apb_master;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 16;

  // ---------------- clock / reset ----------------
  logic          pclk;
  logic          prstn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic [AW-1:0] paddr;
  logic          pselx;
  logic          penable;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic          pready;
  logic [DW-1:0] prdata;
  logic          pslverr;

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .prstn(prstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .pselx(pselx), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  // ---------------- model state ----------------
  typedef struct packed {
    logic          cmd_ready;
    logic          pselx;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
  } obs_t;
  localparam int OW = $bits(obs_t);

  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [5:0]    waits;
    logic          err;
    logic [DW-1:0] rdata;
    logic [3:0]    rdelay;
    logic [2:0]    gap;
  } txn_t;

  logic [OW-1:0] exp_q[$];

  // Bus-side values of the last accepted command and the last response.
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_write;
  logic [DW-1:0] m_rdata;
  logic          m_err;
  logic          m_to;
  bit            force_wait_err;

  int checks;
  int errors;

  // Observations used by the literal checks.
  int            cyc;
  int            pen_cycles;
  int            psel_cycles;
  int            last_acc;
  int            prev_acc;
  logic [DW-1:0] cap_rdata;
  logic          cap_err;
  logic          cap_to;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic obs_t expect_cycle(input logic cr, input logic ps, input logic pe, input logic rv);
    obs_t e;
    e.cmd_ready   = cr;
    e.pselx       = ps;
    e.penable     = pe;
    e.pwrite      = m_write;
    e.paddr       = m_addr;
    e.pwdata      = m_wdata;
    e.rsp_valid   = rv;
    e.rsp_rdata   = rv ? m_rdata : '0;
    e.rsp_err     = rv ? m_err : 1'b0;
    e.rsp_timeout = rv ? m_to : 1'b0;
    return e;
  endfunction

  function automatic txn_t mk_txn(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                  input int waits, input logic err, input logic [DW-1:0] rd,
                                  input int rdelay, input int gap);
    txn_t t;
    t.write  = w;
    t.addr   = a;
    t.wdata  = wd;
    t.waits  = 6'(waits);
    t.err    = err;
    t.rdata  = rd;
    t.rdelay = 4'(rdelay);
    t.gap    = 3'(gap);
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.write  = 1'($urandom);
    t.addr   = AW'($urandom);
    t.wdata  = DW'($urandom);
    t.waits  = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(14, 20)) : 6'($urandom_range(0, 3));
    t.err    = ($urandom_range(0, 3) == 0);
    t.rdata  = DW'($urandom);
    t.rdelay = 4'($urandom_range(0, 6));
    t.gap    = 3'($urandom_range(0, 3));
    return t;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge pclk) begin
    obs_t e;
    obs_t g;
    if (exp_q.size() > 0) begin
      e = obs_t'(exp_q.pop_front());
      g.cmd_ready   = cmd_ready;
      g.pselx       = pselx;
      g.penable     = penable;
      g.pwrite      = pwrite;
      g.paddr       = paddr;
      g.pwdata      = pwdata;
      g.rsp_valid   = rsp_valid;
      g.rsp_rdata   = e.rsp_valid ? rsp_rdata : '0;
      g.rsp_err     = e.rsp_valid ? rsp_err : 1'b0;
      g.rsp_timeout = e.rsp_valid ? rsp_timeout : 1'b0;
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL cycle_outputs at %0t got=%h want=%h (rdy,sel,en,wr,addr,wdata,rv,rdata,err,to)",
                 $time, g, e);
      end
    end
  end

  // ---------------- observation monitor ----------------
  always @(posedge pclk) cyc++;

  always @(negedge pclk) begin
    if (penable) pen_cycles++;
    if (pselx) psel_cycles++;
    if (rsp_valid) begin
      cap_rdata = rsp_rdata;
      cap_err   = rsp_err;
      cap_to    = rsp_timeout;
    end
    if (cmd_valid && cmd_ready) begin
      prev_acc = last_acc;
      last_acc = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input obs_t e);
    exp_q.push_back(e);
    @(posedge pclk);
    #1;
  endtask

  task automatic noise();
    pready  = 1'($urandom);
    prdata  = DW'($urandom);
    pslverr = 1'($urandom);
  endtask

  task automatic idle_cmd();
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_wdata = DW'($urandom);
  endtask

  task automatic drive_busy(input bit hold, input txn_t nt);
    if (hold) begin
      cmd_valid = 1'b1;
      cmd_write = nt.write;
      cmd_addr  = nt.addr;
      cmd_wdata = nt.wdata;
    end else begin
      idle_cmd();
    end
  endtask

  task automatic reset_model();
    m_addr  = '0;
    m_wdata = '0;
    m_write = 1'b0;
    m_rdata = '0;
    m_err   = 1'b0;
    m_to    = 1'b0;
  endtask

  // Runs one transaction. When hold is set, the next command is presented
  // and held from the SETUP cycle onward so that it is taken back-to-back.
  task automatic run_txn(input txn_t t, input bit hold, input txn_t nt);
    bit is_to;
    int n_acc;
    for (int i = 0; i < int'(t.gap); i++) begin
      idle_cmd();
      noise();
      rsp_ready = 1'($urandom);
      step(expect_cycle(1'b1, 1'b0, 1'b0, 1'b0));
    end
    cmd_valid = 1'b1;
    cmd_write = t.write;
    cmd_addr  = t.addr;
    cmd_wdata = t.wdata;
    noise();
    rsp_ready = 1'($urandom);
    step(expect_cycle(1'b1, 1'b0, 1'b0, 1'b0));
    m_addr  = t.addr;
    m_write = t.write;
    m_wdata = t.wdata;
    drive_busy(hold, nt);
    noise();
    rsp_ready = 1'($urandom);
    step(expect_cycle(1'b0, 1'b1, 1'b0, 1'b0));
    is_to = (TO != 0) && (int'(t.waits) >= TO);
    n_acc = is_to ? TO : int'(t.waits) + 1;
    for (int i = 0; i < n_acc; i++) begin
      drive_busy(hold, nt);
      rsp_ready = 1'($urandom);
      if (!is_to && i == int'(t.waits)) begin
        pready  = 1'b1;
        prdata  = t.rdata;
        pslverr = t.err;
      end else begin
        pready  = 1'b0;
        prdata  = DW'($urandom);
        pslverr = force_wait_err ? 1'b1 : 1'($urandom);
      end
      step(expect_cycle(1'b0, 1'b1, 1'b1, 1'b0));
    end
    m_to    = is_to;
    m_err   = is_to ? 1'b1 : t.err;
    m_rdata = (is_to || t.write) ? '0 : t.rdata;
    for (int i = 0; i <= int'(t.rdelay); i++) begin
      drive_busy(hold, nt);
      noise();
      rsp_ready = (i == int'(t.rdelay));
      step(expect_cycle(1'b0, 1'b0, 1'b0, 1'b1));
    end
    rsp_ready = 1'b0;
  endtask

  task automatic clear_obs();
    pen_cycles  = 0;
    psel_cycles = 0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not complete got=running want=done");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    txn_t a;
    txn_t b;
    txn_t c;
    txn_t cur;
    txn_t nxt;
    bit   hold;

    checks = 0;
    errors = 0;
    cyc = 0;
    last_acc = 0;
    prev_acc = 0;
    cap_rdata = '0;
    cap_err = 1'b0;
    cap_to = 1'b0;
    force_wait_err = 1'b0;
    clear_obs();
    reset_model();
    prstn = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    pready = 1'b0;
    prdata = '0;
    pslverr = 1'b0;

    #1;
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_pselx", 32'(pselx), 32'd0);
    check("reset_penable", 32'(penable), 32'd0);
    check("reset_pwrite", 32'(pwrite), 32'd0);
    check("reset_paddr", 32'(paddr), 32'd0);
    check("reset_pwdata", 32'(pwdata), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    check("reset_rsp_timeout", 32'(rsp_timeout), 32'd0);
    @(posedge pclk);
    @(posedge pclk);
    #1;
    prstn = 1'b1;

    // Zero-wait write.
    clear_obs();
    a = mk_txn(1'b1, 8'h04, 8'hA5, 0, 1'b0, 8'h77, 0, 1);
    run_txn(a, 1'b0, a);
    check("wr0_penable_cycles", 32'(pen_cycles), 32'd1);
    check("wr0_pselx_cycles", 32'(psel_cycles), 32'd2);
    check("wr0_rsp_rdata", 32'(cap_rdata), 32'h00);
    check("wr0_rsp_err", 32'(cap_err), 32'd0);

    // Read with two wait states.
    clear_obs();
    a = mk_txn(1'b0, 8'h00, 8'h11, 2, 1'b0, 8'h3C, 1, 1);
    run_txn(a, 1'b0, a);
    check("rd2_penable_cycles", 32'(pen_cycles), 32'd3);
    check("rd2_rsp_rdata", 32'(cap_rdata), 32'h3C);
    check("rd2_rsp_err", 32'(cap_err), 32'd0);

    // Slave error on the ready cycle.
    a = mk_txn(1'b0, 8'h10, 8'h00, 0, 1'b1, 8'hFF, 0, 0);
    run_txn(a, 1'b0, a);
    check("slverr_rsp_err", 32'(cap_err), 32'd1);
    check("slverr_rsp_timeout", 32'(cap_to), 32'd0);
    check("slverr_rsp_rdata", 32'(cap_rdata), 32'hFF);

    // pslverr during wait cycles must not leak into the response.
    force_wait_err = 1'b1;
    a = mk_txn(1'b0, 8'h12, 8'h00, 3, 1'b0, 8'h66, 0, 1);
    run_txn(a, 1'b0, a);
    force_wait_err = 1'b0;
    check("waiterr_rsp_err", 32'(cap_err), 32'd0);
    check("waiterr_rsp_rdata", 32'(cap_rdata), 32'h66);

    // Timeout with pready held low.
    clear_obs();
    a = mk_txn(1'b0, 8'h30, 8'h00, 40, 1'b0, 8'hAA, 2, 1);
    run_txn(a, 1'b0, a);
    check("timeout_penable_cycles", 32'(pen_cycles), 32'd16);
    check("timeout_pselx_cycles", 32'(psel_cycles), 32'd17);
    check("timeout_rsp_err", 32'(cap_err), 32'd1);
    check("timeout_rsp_timeout", 32'(cap_to), 32'd1);
    check("timeout_rsp_rdata", 32'(cap_rdata), 32'h00);

    // One wait short of the timeout still completes normally.
    clear_obs();
    a = mk_txn(1'b0, 8'h31, 8'h00, 15, 1'b0, 8'h5A, 0, 0);
    run_txn(a, 1'b0, a);
    check("edge15_penable_cycles", 32'(pen_cycles), 32'd16);
    check("edge15_rsp_timeout", 32'(cap_to), 32'd0);
    check("edge15_rsp_rdata", 32'(cap_rdata), 32'h5A);

    // Exactly TIMEOUT waits on a write aborts.
    a = mk_txn(1'b1, 8'h32, 8'hC3, 16, 1'b0, 8'h00, 0, 0);
    run_txn(a, 1'b0, a);
    check("edge16_rsp_timeout", 32'(cap_to), 32'd1);

    // Back-to-back with response backpressure, then zero-wait spacing.
    a = mk_txn(1'b1, 8'h21, 8'h5E, 0, 1'b0, 8'h00, 5, 1);
    b = mk_txn(1'b0, 8'h22, 8'h00, 0, 1'b0, 8'h9D, 0, 0);
    c = mk_txn(1'b1, 8'h23, 8'h4B, 0, 1'b0, 8'h00, 0, 0);
    run_txn(a, 1'b1, b);
    run_txn(b, 1'b1, c);
    check("b2b_backpressure_spacing", 32'(last_acc - prev_acc), 32'd9);
    run_txn(c, 1'b0, c);
    check("b2b_zero_wait_spacing", 32'(last_acc - prev_acc), 32'd4);

    // Reset asserted in the middle of ACCESS.
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 8'h55;
    cmd_wdata = 8'h99;
    pready    = 1'b0;
    rsp_ready = 1'b0;
    step(expect_cycle(1'b1, 1'b0, 1'b0, 1'b0));
    m_addr  = 8'h55;
    m_write = 1'b0;
    m_wdata = 8'h99;
    idle_cmd();
    pready = 1'b0;
    step(expect_cycle(1'b0, 1'b1, 1'b0, 1'b0));
    pready = 1'b0;
    check("prereset_penable", 32'(penable), 32'd1);
    #2;
    prstn = 1'b0;
    #1;
    check("midreset_pselx", 32'(pselx), 32'd0);
    check("midreset_penable", 32'(penable), 32'd0);
    check("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midreset_cmd_ready", 32'(cmd_ready), 32'd1);
    reset_model();
    pready = 1'b1;
    @(posedge pclk);
    #1;
    prstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle_cmd();
      noise();
      rsp_ready = 1'b0;
      step(expect_cycle(1'b1, 1'b0, 1'b0, 1'b0));
    end
    check("postreset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("postreset_rsp_rdata", 32'(rsp_rdata), 32'd0);

    // Randomized traffic.
    cur = rand_txn();
    for (int k = 0; k < 80; k++) begin
      nxt  = rand_txn();
      hold = ($urandom_range(0, 3) == 0);
      if (hold) nxt.gap = 3'd0;
      run_txn(cur, hold, nxt);
      cur = nxt;
    end
    run_txn(cur, 1'b0, cur);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
